wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter. It merges a single-cycle result stream (A) and a
// multi-cycle result stream (B) onto one register-file write port. A has
// priority until B has been refused STARVE_LIMIT cycles in a row; B then
// wins until it transfers. The write port is registered, and a write-to-read
// bypass is provided for two read ports.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data,
  output logic        starve
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0]  b_wait_reg, b_wait_next;
  logic        rf_wen_reg, rf_wen_next;
  logic [4:0]  rf_waddr_reg, rf_waddr_next;
  logic [31:0] rf_wdata_reg, rf_wdata_next;

  logic        a_xfer, b_xfer, any_xfer;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;

  // B takes priority once it has waited long enough
  assign starve  = (b_wait_reg >= LIMIT);
  assign a_ready = !(starve && b_valid);
  assign b_ready = !a_valid || starve;

  // The ready equations make the two transfers mutually exclusive
  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;
  assign any_xfer = a_xfer || b_xfer;

  // Select the result being accepted this cycle
  always_comb begin
    grant_rd   = a_rd;
    grant_data = a_data;
    if (b_xfer) begin
      grant_rd   = b_rd;
      grant_data = b_data;
    end
  end

  // Refusal counter: saturating count of cycles B was held off
  always_comb begin
    b_wait_next = b_wait_reg;
    if (b_xfer) begin
      b_wait_next = 3'd0;
    end else if (b_valid && (b_wait_reg != 3'd7)) begin
      b_wait_next = b_wait_reg + 3'd1;
    end
  end

  // Next write-port contents; x0 writes update address/data but never enable
  always_comb begin
    rf_wen_next   = any_xfer && (grant_rd != 5'd0);
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    if (any_xfer) begin
      rf_waddr_next = grant_rd;
      rf_wdata_next = grant_data;
    end
  end

  // State registers, cleared asynchronously so nothing accepted under reset survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_wait_reg   <= 3'd0;
      rf_wen_reg   <= 1'b0;
      rf_waddr_reg <= 5'd0;
      rf_wdata_reg <= 32'd0;
    end else begin
      b_wait_reg   <= b_wait_next;
      rf_wen_reg   <= rf_wen_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
    end
  end

  assign rf_wen   = rf_wen_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;

  // Bypass: both read ports compare against the registered write
  logic [4:0]  raddr_arr [2];
  logic        fwd_hit_arr [2];
  logic [31:0] fwd_data_arr [2];

  assign raddr_arr[0] = raddr1;
  assign raddr_arr[1] = raddr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_hit_arr[gi]  = rf_wen_reg && (raddr_arr[gi] == rf_waddr_reg) &&
                                (raddr_arr[gi] != 5'd0);
      assign fwd_data_arr[gi] = rf_wdata_reg;
    end
  endgenerate

  assign fwd1_hit  = fwd_hit_arr[0];
  assign fwd2_hit  = fwd_hit_arr[1];
  assign fwd1_data = fwd_data_arr[0];
  assign fwd2_data = fwd_data_arr[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a behavioural model checked every cycle, plus
// directed vectors with literal expectations.
module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1, raddr2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic        starve;

  int pass_cnt = 0;
  int total_cnt = 0;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Model tracks how many consecutive cycles B has been refused and the
  // most recent accepted result (which is what the write port must show).
  int          m_refused = 0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wdata = 32'd0;

  // Compare on the falling edge, advance the model on the rising edge
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        m_refused = 0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        check("m_rst_wen", {31'd0, rf_wen}, 32'd0);
        check("m_rst_starve", {31'd0, starve}, 32'd0);
      end else begin
        automatic bit b_has_prio = (m_refused >= LIMIT);
        automatic bit exp_ar = !(b_has_prio && b_valid);
        automatic bit exp_br = !a_valid || b_has_prio;
        check("m_starve", {31'd0, starve}, {31'd0, b_has_prio});
        check("m_a_ready", {31'd0, a_ready}, {31'd0, exp_ar});
        check("m_b_ready", {31'd0, b_ready}, {31'd0, exp_br});
        check("m_rf_wen", {31'd0, rf_wen}, {31'd0, m_wen});
        check("m_rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
        check("m_rf_wdata", rf_wdata, m_wdata);
        check("m_fwd1_hit", {31'd0, fwd1_hit},
              {31'd0, m_wen && raddr1 == m_waddr && raddr1 != 0});
        check("m_fwd2_hit", {31'd0, fwd2_hit},
              {31'd0, m_wen && raddr2 == m_waddr && raddr2 != 0});
        check("m_fwd1_data", fwd1_data, m_wdata);
        check("m_fwd2_data", fwd2_data, m_wdata);
      end
      @(posedge clk);
      if (rst) begin
        m_refused = 0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
      end else begin
        // Priority rule: lone requester wins; on contention B wins only when starved
        automatic bit b_has_prio = (m_refused >= LIMIT);
        automatic bit take_b = b_valid && (!a_valid || b_has_prio);
        automatic bit take_a = a_valid && !take_b;
        if (take_b) begin
          m_refused = 0;
          m_waddr = b_rd; m_wdata = b_data; m_wen = (b_rd != 0);
          $display("xfer port=B rd=%0d data=0x%08h", b_rd, b_data);
        end else begin
          if (b_valid) m_refused = (m_refused < 7) ? m_refused + 1 : 7;
          if (take_a) begin
            m_waddr = a_rd; m_wdata = a_data; m_wen = (a_rd != 0);
            $display("xfer port=A rd=%0d data=0x%08h", a_rd, a_data);
          end else begin
            m_wen = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Mixed pattern table: {a_valid, b_valid, raddr1, raddr2}
  logic [11:0] mix_tab [16] = '{
    {1'b1, 1'b0, 5'd3, 5'd0}, {1'b0, 1'b1, 5'd3, 5'd8}, {1'b1, 1'b1, 5'd8, 5'd3},
    {1'b1, 1'b1, 5'd2, 5'd2}, {1'b0, 1'b0, 5'd2, 5'd0}, {1'b1, 1'b1, 5'd0, 5'd0},
    {1'b1, 1'b1, 5'd4, 5'd5}, {1'b1, 1'b1, 5'd6, 5'd6}, {1'b1, 1'b1, 5'd8, 5'd7},
    {1'b1, 1'b1, 5'd8, 5'd8}, {1'b1, 1'b0, 5'd9, 5'd1}, {1'b0, 1'b1, 5'd1, 5'd9},
    {1'b0, 1'b0, 5'd8, 5'd0}, {1'b1, 1'b0, 5'd0, 5'd1}, {1'b1, 1'b1, 5'd1, 5'd1},
    {1'b0, 1'b0, 5'd1, 5'd0}
  };

  initial begin : stim
    rst = 1'b1;
    a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
    raddr1 = 0; raddr2 = 0;
    repeat (2) cyc();
    check("rst_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_starve", {31'd0, starve}, 32'd0);
    check("rst_fwd1", {31'd0, fwd1_hit}, 32'd0);
    rst = 1'b0;

    // A only
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    #1 check("a_only_ready", {31'd0, a_ready}, 32'd1);
    cyc();
    a_valid = 0;
    #1;
    check("a_only_wen", {31'd0, rf_wen}, 32'd1);
    check("a_only_waddr", {27'd0, rf_waddr}, 32'd5);
    check("a_only_wdata", rf_wdata, 32'hDEADBEEF);

    // Idle cycle: enable drops, address/data hold
    cyc();
    check("idle_wen", {31'd0, rf_wen}, 32'd0);
    check("idle_waddr", {27'd0, rf_waddr}, 32'd5);
    check("idle_wdata", rf_wdata, 32'hDEADBEEF);

    // Bypass
    a_valid = 1; a_rd = 7; a_data = 32'h55;
    cyc();
    a_valid = 0; raddr1 = 7; raddr2 = 0;
    #1;
    check("byp_fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
    check("byp_fwd1_data", fwd1_data, 32'h55);
    check("byp_fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
    raddr2 = 7;
    #1 check("byp_fwd2_hit7", {31'd0, fwd2_hit}, 32'd1);
    raddr1 = 0; raddr2 = 0;

    // Contention: A wins four times, then B takes priority
    b_valid = 1; b_rd = 9; b_data = 32'hB0B;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_rd = 5'(i + 1); a_data = 32'hA0 + i;
      #1;
      check("cont_a_ready", {31'd0, a_ready}, 32'd1);
      check("cont_b_ready", {31'd0, b_ready}, 32'd0);
      cyc();
    end
    a_rd = 5; a_data = 32'hA4;
    #1;
    check("cont_starve", {31'd0, starve}, 32'd1);
    check("cont_a_held", {31'd0, a_ready}, 32'd0);
    check("cont_b_go", {31'd0, b_ready}, 32'd1);
    check("cont_last_a", rf_wdata, 32'hA3);
    cyc();
    b_valid = 0;
    #1;
    check("cont_b_waddr", {27'd0, rf_waddr}, 32'd9);
    check("cont_b_wdata", rf_wdata, 32'hB0B);
    check("cont_unstarve", {31'd0, starve}, 32'd0);
    cyc();
    a_valid = 0;
    check("cont_a4_wdata", rf_wdata, 32'hA4);

    // x0 result consumed but not written
    b_valid = 1; b_rd = 0; b_data = 32'h1234;
    #1 check("x0_b_ready", {31'd0, b_ready}, 32'd1);
    cyc();
    b_valid = 0;
    #1;
    check("x0_wen", {31'd0, rf_wen}, 32'd0);
    check("x0_wdata", rf_wdata, 32'h1234);

    // Mixed patterns checked by the model only
    for (int i = 0; i < 16; i++) begin
      a_valid = mix_tab[i][11]; b_valid = mix_tab[i][10];
      raddr1 = mix_tab[i][9:5]; raddr2 = mix_tab[i][4:0];
      a_rd = 5'(i % 9); a_data = 32'h1000 + i;
      if (!(b_valid && !b_ready)) begin
        b_rd = 5'((i * 3) % 10); b_data = 32'h2000 + i;
      end
      cyc();
    end
    a_valid = 0; b_valid = 0; raddr1 = 0; raddr2 = 0;
    cyc();

    // Reset mid-operation, between clock edges
    b_valid = 1; b_rd = 12; b_data = 32'hC0C;
    b_valid = 0;
    cyc();
    b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_rd = 5'(20 + i); a_data = 32'hE0 + i;
      cyc();
    end
    raddr1 = 23;
    #1;
    check("pre_rst_wen", {31'd0, rf_wen}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_wen", {31'd0, rf_wen}, 32'd0);
    check("arst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("arst_wdata", rf_wdata, 32'd0);
    check("arst_starve", {31'd0, starve}, 32'd0);
    check("arst_fwd1", {31'd0, fwd1_hit}, 32'd0);
    a_valid = 0; b_valid = 0; raddr1 = 0;
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_wen", {31'd0, rf_wen}, 32'd0);
    a_valid = 1; a_rd = 3; a_data = 32'h77;
    cyc();
    a_valid = 0;
    check("post_rst_write", rf_wdata, 32'h77);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety net so the run always ends
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
